// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
//   Definitions shared by the serial-link receiver and its transmit partner:
//   default bit timing, the receiver state encoding and the parity convention.
//
//   Contents
//     CLKS_PER_BIT_DEF  clk_3125 cycles per serial bit
//     SAMPLE_PT_DEF     counter value at which a bit is sampled (~bit centre)
//     PARITY_EVEN/ODD   parity_type encodings (0 = even, 1 = odd)
//     rx_state_t        3-bit receiver state encoding
//     parity_bit()      parity bit a transmitter sends for a byte
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  localparam int CLKS_PER_BIT_DEF = 14;
  localparam int SAMPLE_PT_DEF    = 4;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_RECOVER = 3'd5
  } rx_state_t;

  // Even parity sends ^data, odd parity sends its complement.
  function automatic logic parity_bit(input logic [7:0] data, input logic ptype);
    return (^data) ^ ptype;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
//   Signal bundle between a serial line source and the receiver.
//
//   rx           serial line, idle high, asynchronous to clk_3125
//   parity_type  0 = even, 1 = odd; static for the whole frame
//   rx_data      last received byte, held until the next rx_done
//   rx_done      one-cycle strobe: rx_data/parity_err/frame_err just updated
//   parity_err   received parity bit differs from the expected one
//   frame_err    stop bit sampled low
//
//   Handshake: rx_done is a valid-only strobe with no ready; the consumer must
//   take the byte in the cycle rx_done is high or read the held rx_data later.
//   There is no backpressure, a later frame simply overwrites the result.
//
//   master: drives the line (line source / test driver)
//   slave : the receiver
// -----------------------------------------------------------------------------
interface uart_rx_if;

  logic       rx;
  logic       parity_type;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;

  modport master (
    output rx,
    output parity_type,
    input  rx_data,
    input  rx_done,
    input  parity_err,
    input  frame_err
  );

  modport slave (
    input  rx,
    input  parity_type,
    output rx_data,
    output rx_done,
    output parity_err,
    output frame_err
  );

endinterface

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
//   Two-flop synchroniser for the asynchronous serial line. Resets to 1 so the
//   idle-high line does not look like a start edge coming out of reset.
//
//   clk_3125  in  system clock
//   rst_n     in  synchronous active-low reset
//   d         in  asynchronous input
//   q         out synchronised output (two cycles of latency)
// -----------------------------------------------------------------------------
module uart_rx_sync (
  input  logic clk_3125,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_3125) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   Receive half of the colour-detector serial link. Frame format:
//   start(0), 8 data bits MSB first, parity, stop(1); CLKS_PER_BIT cycles per
//   bit. Each bit is sampled once when the bit counter equals SAMPLE_PT.
//
//   clk_3125  in  system clock, all logic on posedge
//   rst_n     in  synchronous active-low reset
//   bus       slave side of uart_rx_if (rx, parity_type in; results out)
//   state     out current FSM state, for observation
//
//   Timing from the first clock edge k that sees rx low: rx_s low after k+1,
//   START entered at k+2, bit n (start=0 .. stop=10) sampled at k+14n+7,
//   rx_done high in the cycle after k+147. The receiver is back in IDLE before
//   a back-to-back transmitter can issue its next start bit.
// -----------------------------------------------------------------------------
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int SAMPLE_PT    = SAMPLE_PT_DEF
) (
  input  logic       clk_3125,
  input  logic       rst_n,
  uart_rx_if.slave   bus,
  output rx_state_t  state
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] CNT_SAMPLE = CW'(SAMPLE_PT);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);

  rx_state_t   state_q;
  rx_state_t   state_d;

  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_rx;

  logic [7:0]    rx_data_q;
  logic          rx_done_q;
  logic          parity_err_q;
  logic          frame_err_q;

  logic at_sample;
  logic at_end;

  // Decoded per-cycle controls from the output process.
  logic cnt_clr;
  logic cnt_inc;
  logic bit_clr;
  logic bit_inc;
  logic shift_en;
  logic par_en;
  logic done_en;

  uart_rx_sync u_sync (
    .clk_3125 (clk_3125),
    .rst_n    (rst_n),
    .d        (bus.rx),
    .q        (rx_s)
  );

  assign at_sample = (cnt == CNT_SAMPLE);
  assign at_end    = (cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_3125) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        // A line that is high again at mid start bit was a glitch.
        if (at_sample && rx_s) state_d = ST_IDLE;
        else if (at_end)       state_d = ST_DATA;
      end
      ST_DATA: begin
        if (at_end && (bit_cnt == 3'd7)) state_d = ST_PARITY;
      end
      ST_PARITY: begin
        if (at_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Leave at mid stop bit so the next start edge is never missed.
        if (at_sample) state_d = rx_s ? ST_IDLE : ST_RECOVER;
      end
      ST_RECOVER: begin
        // A held-low line (break) must go high before a new frame can start.
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    bit_clr  = 1'b0;
    bit_inc  = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    done_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
      end
      ST_START: begin
        if (at_end) begin
          cnt_clr = 1'b1;
          bit_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_DATA: begin
        shift_en = at_sample;
        if (at_end) begin
          cnt_clr = 1'b1;
          if (bit_cnt == 3'd7) bit_clr = 1'b1;
          else                 bit_inc = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_PARITY: begin
        par_en = at_sample;
        if (at_end) cnt_clr = 1'b1;
        else        cnt_inc = 1'b1;
      end
      ST_STOP: begin
        done_en = at_sample;
        if (at_sample) cnt_clr = 1'b1;
        else           cnt_inc = 1'b1;
      end
      ST_RECOVER: begin
        cnt_clr = 1'b1;
      end
      default: begin
        cnt_clr = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: counters, shift register and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_3125) begin
    if (!rst_n) begin
      cnt          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_rx       <= 1'b0;
      rx_data_q    <= '0;
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;

      if (bit_clr)      bit_cnt <= '0;
      else if (bit_inc) bit_cnt <= bit_cnt + 1'b1;

      // MSB arrives first, so after eight shifts it sits in bit 7.
      if (shift_en) shreg <= {shreg[6:0], rx_s};

      if (par_en) par_rx <= rx_s;

      rx_done_q <= done_en;
      if (done_en) begin
        rx_data_q    <= shreg;
        parity_err_q <= par_rx ^ parity_bit(shreg, bus.parity_type);
        frame_err_q  <= ~rx_s;
      end
    end
  end

  assign bus.rx_data    = rx_data_q;
  assign bus.rx_done    = rx_done_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign state          = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Drives serial frames into uart_rx and checks decoded bytes, error flags
//   and rx_done timing against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int CPB         = 14;
  localparam int DONE_LAT    = 148;  // negedge of start drive -> negedge seeing rx_done

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic      clk_3125 = 1'b0;
  logic      rst_n    = 1'b0;
  rx_state_t state;

  always #5 clk_3125 = ~clk_3125;

  uart_rx_if bus ();

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .SAMPLE_PT    (4)
  ) dut (
    .clk_3125 (clk_3125),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .state    (state)
  );

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  always @(posedge clk_3125) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a frame decodes to its byte; parity error when the sent
  // parity bit differs from the number-of-ones rule; framing error when the
  // stop bit is low.
  // ---------------------------------------------------------------------------
  function automatic logic model_parity(input logic [7:0] d, input logic ptype);
    int ones;
    ones = $countones(d);
    return ((ones % 2) == 1) ? ~ptype : ptype;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard: {rx_data, parity_err, frame_err, done cycle}
  // ---------------------------------------------------------------------------
  logic [41:0] exp_q[$];
  logic [41:0] mon_e;
  logic        prev_done = 1'b0;

  always @(negedge clk_3125) begin
    if (bus.rx_done === 1'b1) begin
      check("done_width", 32'(prev_done), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: actual=1 required=0 rx_data=%0h (cycle %0d)", bus.rx_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("rx_data",    32'(bus.rx_data),    32'(mon_e[41:34]));
        check("parity_err", 32'(bus.parity_err), 32'(mon_e[33]));
        check("frame_err",  32'(bus.frame_err),  32'(mon_e[32]));
        check("done_cycle", 32'(cyc),            mon_e[31:0]);
      end
    end
    prev_done = (bus.rx_done === 1'b1);
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic send_frame(input logic [7:0] d, input logic ptype, input logic par_bit,
                            input logic stop_bit, input int low_len, input int gap,
                            input logic exp_pe, input logic exp_fe);
    int n;
    bus.parity_type = ptype;
    @(negedge clk_3125);
    bus.rx = 1'b0;
    exp_q.push_back({d, exp_pe, exp_fe, 32'(cyc + DONE_LAT)});
    repeat (CPB) @(negedge clk_3125);
    for (int i = 7; i >= 0; i--) begin
      bus.rx = d[i];
      repeat (CPB) @(negedge clk_3125);
    end
    bus.rx = par_bit;
    repeat (CPB) @(negedge clk_3125);
    bus.rx = stop_bit;
    if (stop_bit) begin
      repeat (CPB) @(negedge clk_3125);
    end else begin
      n = (low_len > CPB) ? low_len : CPB;
      if (n >= 30) begin
        repeat (25) @(negedge clk_3125);
        check("recover_hold", 32'(state), 32'(ST_RECOVER));
        repeat (n - 25) @(negedge clk_3125);
      end else begin
        repeat (n) @(negedge clk_3125);
      end
    end
    bus.rx = 1'b1;
    repeat (gap) @(negedge clk_3125);
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    check({tag, "_data"}, 32'(bus.rx_data),    32'(d));
    check({tag, "_pe"},   32'(bus.parity_err), 32'(pe));
    check({tag, "_fe"},   32'(bus.frame_err),  32'(fe));
    check({tag, "_done"}, 32'(bus.rx_done),    32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] data;
    logic       ptype;
    logic       par_bit;
    logic       stop_bit;
    int         low_len;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0] d;
    logic       pt;
    logic       bad;
    logic       stp;

    bus.rx          = 1'b1;
    bus.parity_type = 1'b0;
    rst_n           = 1'b0;
    repeat (4) @(negedge clk_3125);
    check_outputs("reset", 8'h00, 1'b0, 1'b0);
    check("reset_state", 32'(state), 32'(ST_IDLE));
    rst_n = 1'b1;
    repeat (5) @(negedge clk_3125);

    //            data  pt    par   stop  low gap exp_d  pe    fe
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1,  0,  3, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1,  0,  3, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{8'h81, 1'b0, 1'b1, 1'b1,  0,  3, 8'h81, 1'b1, 1'b0};
    vecs[3] = '{8'h55, 1'b0, 1'b0, 1'b0, 40, 20, 8'h55, 1'b0, 1'b1};
    vecs[4] = '{8'h0F, 1'b0, 1'b0, 1'b1,  0,  3, 8'h0F, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1,  0,  3, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 1'b1, 1'b0, 1'b0, 14,  4, 8'hFF, 1'b1, 1'b1};
    vecs[7] = '{8'h80, 1'b0, 1'b1, 1'b1,  0,  3, 8'h80, 1'b0, 1'b0};

    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].data, vecs[v].ptype, vecs[v].par_bit, vecs[v].stop_bit,
                 vecs[v].low_len, vecs[v].gap, vecs[v].exp_pe, vecs[v].exp_fe);
      check_outputs($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_pe, vecs[v].exp_fe);
      check($sformatf("vec%0d_pending", v), 32'(exp_q.size()), 32'd0);
    end

    // Short low glitch on an idle line: START is entered, then abandoned.
    @(negedge clk_3125);
    bus.rx = 1'b0;
    repeat (3) @(negedge clk_3125);
    bus.rx = 1'b1;
    repeat (2) @(negedge clk_3125);
    check("glitch_start", 32'(state), 32'(ST_START));
    repeat (15) @(negedge clk_3125);
    check("glitch_idle", 32'(state), 32'(ST_IDLE));
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 0, 3, 1'b0, 1'b0);
    check_outputs("after_glitch", 8'hC3, 1'b0, 1'b0);

    // Reset in the middle of the data bits: frame dropped, outputs cleared.
    @(negedge clk_3125);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk_3125);
    bus.rx = 1'b1;
    repeat (30) @(negedge clk_3125);
    check("mid_state", 32'(state), 32'(ST_DATA));
    rst_n = 1'b0;
    @(negedge clk_3125);
    rst_n = 1'b1;
    check_outputs("mid_reset", 8'h00, 1'b0, 1'b0);
    check("mid_reset_state", 32'(state), 32'(ST_IDLE));
    repeat (150) @(negedge clk_3125);
    check("mid_reset_quiet", 32'(bus.rx_data), 32'h00);

    // Back-to-back frames with the minimum inter-frame gap.
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    send_frame(8'h34, 1'b0, 1'b1, 1'b1, 0, 5, 1'b0, 1'b0);
    check_outputs("b2b", 8'h34, 1'b0, 1'b0);
    check("b2b_pending", 32'(exp_q.size()), 32'd0);

    // Random frames against the model.
    for (int r = 0; r < 20; r++) begin
      d   = 8'($urandom_range(0, 255));
      pt  = 1'($urandom_range(0, 1));
      bad = ($urandom_range(0, 3) == 0);
      stp = ($urandom_range(0, 4) != 0);
      send_frame(d, pt, model_parity(d, pt) ^ bad, stp,
                 int'($urandom_range(14, 35)), int'($urandom_range(2, 10)),
                 bad, ~stp);
    end

    repeat (20) @(negedge clk_3125);
    check("final_pending", 32'(exp_q.size()), 32'd0);
    check("final_state", 32'(state), 32'(ST_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
